alu_2bit: RTL and testbench

- Registered 2-bit-operand arithmetic/logic unit: two unsigned 2-bit operands, 2-bit opcode, 4-bit result.
- Leaf datapath block for small lab-scale datapaths and controllers; one clock domain.
- Result, valid strobe and status flags are registered, one cycle after accepted inputs.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_2bit_comb.sv | 35 +++
 rtl/alu_2bit.sv | 66 ++++++
 tb/tb_alu_2bit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and width definitions for the 2-bit registered ALU.
// Imported by the combinational datapath and the registered top.
package alu_pkg;

  localparam int W  = 2;
  localparam int RW = 2 * W;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_CMP = 2'b11
  } op_e;

endpackage

// File: rtl/alu_2bit_comb.sv
// Combinational core of the 2-bit ALU: computes the 4-bit result and the
// negative flag for one operation. No state.
module alu_2bit_comb
  import alu_pkg::*;
(
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    sel,
  output logic [RW-1:0] result,
  output logic          neg
);

  logic [RW-1:0] a_ext;
  logic [RW-1:0] b_ext;

  assign a_ext = {2'b00, a};
  assign b_ext = {2'b00, b};

  // Zero-extended operands keep SUB wrapping mod 16, so bit 3 marks a < b.
  always_comb begin
    result = '0;
    neg    = 1'b0;
    case (op_e'(sel))
      OP_ADD: result = a_ext + b_ext;
      OP_SUB: begin
        result = a_ext - b_ext;
        neg    = result[RW-1];
      end
      OP_MUL: result = a_ext * b_ext;
      OP_CMP: result = {1'b0, (a > b), (a == b), (a < b)};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/alu_2bit.sv
// Registered 2-bit ALU: qualifies inputs with in_valid and registers the
// result, a one-cycle valid strobe and the zero/neg flags.
module alu_2bit
  import alu_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    sel,
  output logic [RW-1:0] y,
  output logic          y_valid,
  output logic          zero,
  output logic          neg
);

  logic [RW-1:0] comb_result;
  logic          comb_neg;

  logic [RW-1:0] y_q, y_d;
  logic          y_valid_q, y_valid_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;

  alu_2bit_comb u_comb (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (comb_result),
    .neg    (comb_neg)
  );

  // Result and flags only move on an accepted input; the strobe always follows in_valid.
  always_comb begin
    y_d       = y_q;
    zero_d    = zero_q;
    neg_d     = neg_q;
    y_valid_d = in_valid;
    if (in_valid) begin
      y_d    = comb_result;
      zero_d = (comb_result == '0);
      neg_d  = comb_neg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
      zero_q    <= 1'b0;
      neg_q     <= 1'b0;
    end else begin
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      zero_q    <= zero_d;
      neg_q     <= neg_d;
    end
  end

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign zero    = zero_q;
  assign neg     = neg_q;

endmodule

// File: tb/tb_alu_2bit.sv
// Directed self-checking bench for alu_2bit: reset, each opcode, hold,
// back-to-back throughput and mid-stream asynchronous reset.
module tb_alu_2bit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [1:0] a;
  logic [1:0] b;
  logic [1:0] sel;
  logic [3:0] y;
  logic       y_valid;
  logic       zero;
  logic       neg;

  int errors;
  int checks;

  alu_2bit dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .y        (y),
    .y_valid  (y_valid),
    .zero     (zero),
    .neg      (neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one operation (or an idle cycle) at the falling edge, then look just after the rising edge.
  task automatic drive_op(input logic v, input logic [1:0] op, input logic [1:0] av, input logic [1:0] bv);
    @(negedge clk);
    in_valid = v;
    sel      = op;
    a        = av;
    b        = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string name, input logic [3:0] ey, input logic ev, input logic ez, input logic en);
    checks++;
    if (y !== ey) begin
      errors++;
      $display("[TB] FAIL %s y: got %b expected %b", name, y, ey);
    end
    checks++;
    if (y_valid !== ev) begin
      errors++;
      $display("[TB] FAIL %s y_valid: got %b expected %b", name, y_valid, ev);
    end
    checks++;
    if (zero !== ez) begin
      errors++;
      $display("[TB] FAIL %s zero: got %b expected %b", name, zero, ez);
    end
    checks++;
    if (neg !== en) begin
      errors++;
      $display("[TB] FAIL %s neg: got %b expected %b", name, neg, en);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 2'($urandom_range(0, 3));
    b        = 2'($urandom_range(0, 3));
    sel      = 2'($urandom_range(0, 3));
    #2;
    check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_add();
    logic [1:0] av [4];
    logic [1:0] bv [4];
    logic [3:0] ey [4];
    av = '{2'b00, 2'b10, 2'b10, 2'b11};
    bv = '{2'b00, 2'b01, 2'b10, 2'b11};
    ey = '{4'b0000, 4'b0011, 4'b0100, 4'b0110};
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, 2'b00, av[i], bv[i]);
      check_all($sformatf("add%0d", i), ey[i], 1'b1, (i == 0), 1'b0);
    end
  endtask

  task automatic test_sub();
    logic [1:0] av [5];
    logic [1:0] bv [5];
    logic [3:0] ey [5];
    logic       ez [5];
    logic       en [5];
    av = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b01};
    bv = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b10};
    ey = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b1111};
    ez = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    en = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive_op(1'b1, 2'b01, av[i], bv[i]);
      check_all($sformatf("sub%0d", i), ey[i], 1'b1, ez[i], en[i]);
    end
  endtask

  task automatic test_mul();
    logic [1:0] av [4];
    logic [1:0] bv [4];
    logic [3:0] ey [4];
    av = '{2'b00, 2'b10, 2'b10, 2'b11};
    bv = '{2'b00, 2'b01, 2'b10, 2'b11};
    ey = '{4'b0000, 4'b0010, 4'b0100, 4'b1001};
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b1, 2'b10, av[i], bv[i]);
      check_all($sformatf("mul%0d", i), ey[i], 1'b1, (i == 0), 1'b0);
    end
  endtask

  task automatic test_cmp();
    logic [1:0] av [5];
    logic [1:0] bv [5];
    logic [3:0] ey [5];
    av = '{2'b00, 2'b10, 2'b10, 2'b11, 2'b01};
    bv = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    ey = '{4'b0010, 4'b0100, 4'b0010, 4'b0010, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      drive_op(1'b1, 2'b11, av[i], bv[i]);
      check_all($sformatf("cmp%0d", i), ey[i], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_hold();
    drive_op(1'b1, 2'b01, 2'b01, 2'b10);
    check_all("hold_accept", 4'b1111, 1'b1, 1'b0, 1'b1);
    drive_op(1'b0, 2'b00, 2'b00, 2'b00);
    check_all("hold_gap1", 4'b1111, 1'b0, 1'b0, 1'b1);
    drive_op(1'b0, 2'b10, 2'b11, 2'b11);
    check_all("hold_gap2", 4'b1111, 1'b0, 1'b0, 1'b1);
    drive_op(1'b1, 2'b00, 2'b00, 2'b00);
    check_all("hold_zero", 4'b0000, 1'b1, 1'b1, 1'b0);
    drive_op(1'b0, 2'b10, 2'b11, 2'b10);
    check_all("hold_zero_gap", 4'b0000, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive_op(1'b1, 2'b10, 2'b11, 2'b11);
    check_all("b2b0", 4'b1001, 1'b1, 1'b0, 1'b0);
    drive_op(1'b1, 2'b00, 2'b11, 2'b10);
    check_all("b2b1", 4'b0101, 1'b1, 1'b0, 1'b0);
    drive_op(1'b1, 2'b01, 2'b00, 2'b11);
    check_all("b2b2", 4'b1101, 1'b1, 1'b0, 1'b1);
    drive_op(1'b1, 2'b11, 2'b10, 2'b00);
    check_all("b2b3", 4'b0100, 1'b1, 1'b0, 1'b0);
    drive_op(1'b0, 2'b11, 2'b10, 2'b00);
    check_all("b2b_idle", 4'b0100, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_midstream_reset();
    drive_op(1'b1, 2'b01, 2'b00, 2'b01);
    check_all("mrst_pre", 4'b1111, 1'b1, 1'b0, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_all("mrst_async", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("mrst_held", 4'b0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drive_op(1'b1, 2'b10, 2'b10, 2'b11);
    check_all("mrst_post", 4'b0110, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rst      = 1'b0;
    in_valid = 1'b0;
    a        = 2'b00;
    b        = 2'b00;
    sel      = 2'b00;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_cmp();
    test_hold();
    test_back_to_back();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
